// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the GPU memory interconnect.
package gpu_mem_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    // One slave-side request as seen by the DRAM port.
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // Master ID width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the requesting masters, the arbiter and the DRAM port.
interface mem_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]                 i_req;
    logic [NUM_MASTERS-1:0]                 i_we;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_addr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_wdata;
    logic [NUM_MASTERS-1:0]                 o_gnt;
    logic [NUM_MASTERS-1:0]                 o_rvalid;
    logic [DATA_WIDTH-1:0]                  o_rdata;
    logic                                   o_mem_req;
    logic                                   o_mem_we;
    logic [ADDR_WIDTH-1:0]                  o_mem_addr;
    logic [DATA_WIDTH-1:0]                  o_mem_wdata;
    logic                                   i_mem_ready;
    logic [DATA_WIDTH-1:0]                  i_mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_ready, i_mem_rdata,
        output o_gnt, o_rvalid, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );

    // Environment side: masters plus the memory model.
    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_ready, i_mem_rdata,
        input  o_gnt, o_rvalid, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// Grant selection: round-robin with a per-owner grant quota, or fixed priority.
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_GRANTS  = 4,
    parameter int ARB_MODE    = 0,
    localparam int ID_W       = id_width(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   advance,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   gnt_any
);
    localparam int              CNT_W   = $clog2(MAX_GRANTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANTS);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_MASTERS - 1);
    localparam arb_mode_e        MODE    = arb_mode_e'(ARB_MODE);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  start;
    logic [ID_W-1:0]  idx_id;
    logic [CNT_W-1:0] cnt;
    logic             found;
    int               idx;

    // Search origin: the owner keeps priority until its quota is used up.
    always_comb begin
        start = '0;
        if (MODE == ARB_RR) begin
            if (req[ptr] && (cnt < CNT_MAX)) start = ptr;
            else if (ptr == LAST_ID)         start = '0;
            else                             start = ptr + ID_W'(1);
        end
    end

    // Circular scan from the origin; the first requester found wins.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        idx_id = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            idx_id = ID_W'(idx);
            if (!found && req[idx_id]) begin
                found  = 1'b1;
                gnt_id = idx_id;
            end
        end
    end

    assign gnt_any = found && advance;
    assign gnt     = gnt_any ? (NUM_MASTERS'(1) << gnt_id) : '0;

    // Owner pointer and saturating consecutive-grant counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if ((MODE == ARB_RR) && gnt_any) begin
            if (gnt_id == ptr) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end else begin
                ptr <= gnt_id;
                cnt <= CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-master to one-slave memory arbiter with issue register and read-response routing.
module mem_arbiter_rr
    import gpu_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = MEM_ADDR_W,
    parameter int DATA_WIDTH  = MEM_DATA_W,
    parameter int RD_LATENCY  = 2,
    parameter int MAX_GRANTS  = 4,
    parameter int ARB_MODE    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_rr_if.slave  bus
);
    localparam int ID_W = id_width(NUM_MASTERS);

    logic                                 can_load;
    logic                                 accept;
    logic                                 gnt_any;
    logic [NUM_MASTERS-1:0]               gnt;
    logic [ID_W-1:0]                      gnt_id;
    logic [ID_W-1:0]                      issue_id;
    logic [RD_LATENCY-1:0]                pipe_vld;
    logic [RD_LATENCY-1:0][ID_W-1:0]      pipe_id;

    // The issue register refills when empty or when being drained this cycle.
    assign accept   = bus.o_mem_req && bus.i_mem_ready;
    assign can_load = rst_n && (!bus.o_mem_req || bus.i_mem_ready);

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .MAX_GRANTS  (MAX_GRANTS),
        .ARB_MODE    (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.i_req),
        .advance (can_load),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign bus.o_gnt = gnt;

    // Issue register: captures the granted master's request for the slave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            issue_id        <= '0;
        end else if (can_load) begin
            bus.o_mem_req <= gnt_any;
            if (gnt_any) begin
                bus.o_mem_we    <= bus.i_we[gnt_id];
                bus.o_mem_addr  <= bus.i_addr[gnt_id];
                bus.o_mem_wdata <= bus.i_wdata[gnt_id];
                issue_id        <= gnt_id;
            end
        end
    end

    // Response tag pipeline: shifts every cycle, reads carry a valid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[0] <= accept && !bus.o_mem_we;
            pipe_id[0]  <= issue_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // Response register: route slave read data to the issuing master for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_rvalid <= '0;
            bus.o_rdata  <= '0;
        end else begin
            bus.o_rvalid <= pipe_vld[RD_LATENCY-1] ? (NUM_MASTERS'(1) << pipe_id[RD_LATENCY-1]) : '0;
            if (pipe_vld[RD_LATENCY-1]) bus.o_rdata <= bus.i_mem_rdata;
        end
    end

    // Grant and response strobes address at most one master.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.o_gnt));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.o_rvalid));

    // A pending request is held until it is granted.
    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (bus.i_req[m] && !bus.o_gnt[m]) |=> bus.i_req[m]);
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: vector table plus multi-cycle sequences.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] m_addr  [4];
    logic [31:0] m_wdata [4];

    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_rr ();
    mem_arbiter_rr_if #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_fx ();

    mem_arbiter_rr #(
        .NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .RD_LATENCY(2), .MAX_GRANTS(2), .ARB_MODE(0)
    ) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));

    mem_arbiter_rr #(
        .NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .RD_LATENCY(2), .MAX_GRANTS(2), .ARB_MODE(1)
    ) dut_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx));

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] rdata;
        logic [3:0]  gnt;
        logic        mreq;
        int          mid;
        logic        mwe;
        logic [3:0]  rv;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] we,
                                input logic [31:0] rdata, input logic [3:0] gnt, input logic mreq,
                                input int mid, input logic mwe, input logic [3:0] rv,
                                input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.rdata = rdata; v.gnt = gnt;
        v.mreq = mreq; v.mid = mid; v.mwe = mwe; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_defaults();
        for (int m = 0; m < 4; m++) begin
            m_addr[m]  = 32'h80 * (m + 1);
            m_wdata[m] = 32'hA000_0000 + m;
        end
    endtask

    task automatic load_bus();
        for (int m = 0; m < 4; m++) begin
            bus_rr.i_addr[m]  = m_addr[m];
            bus_rr.i_wdata[m] = m_wdata[m];
            bus_fx.i_addr[m]  = m_addr[m];
            bus_fx.i_wdata[m] = m_wdata[m];
        end
    endtask

    // One cycle on the round-robin instance: drive after the edge, settle, then caller checks.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] we,
                       input logic ready, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst_n                = !rst;
        bus_rr.i_req         = req;
        bus_rr.i_we          = we;
        bus_rr.i_mem_ready   = ready;
        bus_rr.i_mem_rdata   = rdata;
        load_bus();
        #1;
    endtask

    task automatic cyc_fx(input logic [3:0] req);
        @(posedge clk);
        #1;
        bus_fx.i_req = req;
        #1;
    endtask

    task automatic chk_issue(input string tag, input int mid, input logic we);
        chk({tag, " mem_req"}, 64'(bus_rr.o_mem_req), 64'(1'b1));
        chk({tag, " mem_addr"}, 64'(bus_rr.o_mem_addr), 64'(m_addr[mid]));
        chk({tag, " mem_we"}, 64'(bus_rr.o_mem_we), 64'(we));
        if (we) chk({tag, " mem_wdata"}, 64'(bus_rr.o_mem_wdata), 64'(m_wdata[mid]));
    endtask

    task automatic check_row(input int k, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", k);
        chk({tag, " gnt"}, 64'(bus_rr.o_gnt), 64'(v.gnt));
        if (v.mreq) chk_issue(tag, v.mid, v.mwe);
        else        chk({tag, " mem_req"}, 64'(bus_rr.o_mem_req), 64'(1'b0));
        chk({tag, " rvalid"}, 64'(bus_rr.o_rvalid), 64'(v.rv));
        if (v.rv != 4'b0) chk({tag, " rdata"}, 64'(bus_rr.o_rdata), 64'(v.rd));
        if (v.rst) begin
            chk({tag, " rst mem_addr"}, 64'(bus_rr.o_mem_addr), 64'(0));
            chk({tag, " rst mem_wdata"}, 64'(bus_rr.o_mem_wdata), 64'(0));
            chk({tag, " rst rdata"}, 64'(bus_rr.o_rdata), 64'(0));
        end
    endtask

    initial begin
        set_defaults();
        bus_rr.i_req = '0; bus_rr.i_we = '0; bus_rr.i_mem_ready = 1'b1; bus_rr.i_mem_rdata = '0;
        bus_fx.i_req = '0; bus_fx.i_we = '0; bus_fx.i_mem_ready = 1'b1; bus_fx.i_mem_rdata = '0;
        load_bus();

        // rst req  we   rdata          gnt mreq mid we  rv  rd
        tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 4'h0, 32'h0));
        // four continuous writers, quota 2: 0,0,1,1,2,2,3,3,0 with back-to-back issue
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h1, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h1, 1, 0, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h2, 1, 0, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h2, 1, 1, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h4, 1, 1, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h4, 1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h8, 1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h8, 1, 3, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h0,         4'h1, 1, 3, 1, 4'h0, 32'h0));
        tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 4'h0, 32'h0));
        // single read by master 1 at 0x100: grant t, issue t+1, response t+4
        tbl.push_back(mk(0, 4'h2, 4'h0, 32'h0,         4'h2, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,         4'h0, 1, 1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'hCAFE_0001, 4'h0, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 4'h2, 32'hCAFE_0001));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 4'h0, 32'h0));
        // lone requester past its quota, then a second master joins
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h0,         4'h4, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h0,         4'h4, 1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h0,         4'h4, 1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h5, 4'h5, 32'h0,         4'h1, 1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h5, 4'h5, 32'h0,         4'h1, 1, 0, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h0,         4'h4, 1, 0, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,         4'h0, 1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 4'h0, 32'h0));

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].rst, tbl[k].req, tbl[k].we, 1'b1, tbl[k].rdata);
            check_row(k, tbl[k]);
        end

        // Back-pressure: masters 0 and 2 write, slave stalls for 5 cycles.
        cyc(1, 4'h0, 4'h0, 1'b1, 32'h0);
        cyc(0, 4'h5, 4'h5, 1'b1, 32'h0);
        chk("bp first gnt", 64'(bus_rr.o_gnt), 64'(4'h1));
        for (int c = 0; c < 5; c++) begin
            cyc(0, 4'h5, 4'h5, 1'b0, 32'h0);
            chk($sformatf("bp stall%0d gnt", c), 64'(bus_rr.o_gnt), 64'(4'h0));
            chk_issue($sformatf("bp stall%0d", c), 0, 1'b1);
        end
        begin
            logic [3:0] bp_gnt [4];
            int         bp_mid [4];
            bp_gnt = '{4'h1, 4'h4, 4'h4, 4'h1};
            bp_mid = '{0, 0, 2, 2};
            for (int c = 0; c < 4; c++) begin
                cyc(0, 4'h5, 4'h5, 1'b1, 32'h0);
                chk($sformatf("bp resume%0d gnt", c), 64'(bus_rr.o_gnt), 64'(bp_gnt[c]));
                chk_issue($sformatf("bp resume%0d", c), bp_mid[c], 1'b1);
            end
        end

        // Mixed: master 0 writes 0xDEAD to 0x40, then master 3 reads 0x40.
        cyc(1, 4'h0, 4'h0, 1'b1, 32'h0);
        m_addr[0] = 32'h40; m_wdata[0] = 32'hDEAD; m_addr[3] = 32'h40;
        cyc(0, 4'h1, 4'h1, 1'b1, 32'h0);
        chk("mix gnt0", 64'(bus_rr.o_gnt), 64'(4'h1));
        cyc(0, 4'h8, 4'h0, 1'b1, 32'h0);
        chk("mix gnt3", 64'(bus_rr.o_gnt), 64'(4'h8));
        chk_issue("mix write", 0, 1'b1);
        cyc(0, 4'h0, 4'h0, 1'b1, 32'h0);
        chk_issue("mix read", 3, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 4'h0, 4'h0, 1'b1, (c == 1) ? 32'hDEAD : 32'h0);
            chk($sformatf("mix rvalid%0d", c), 64'(bus_rr.o_rvalid), 64'((c == 2) ? 4'h8 : 4'h0));
            if (c == 2) chk("mix rdata", 64'(bus_rr.o_rdata), 64'(32'hDEAD));
        end
        set_defaults();

        // Reset one cycle after two reads are accepted: outputs clear, responses dropped.
        cyc(1, 4'h0, 4'h0, 1'b1, 32'h0);
        cyc(0, 4'h6, 4'h0, 1'b1, 32'h0);
        chk("rst gnt1", 64'(bus_rr.o_gnt), 64'(4'h2));
        cyc(0, 4'h4, 4'h0, 1'b1, 32'h0);
        chk("rst gnt2", 64'(bus_rr.o_gnt), 64'(4'h4));
        cyc(0, 4'h0, 4'h0, 1'b1, 32'h0);
        chk_issue("rst issue2", 2, 1'b0);
        cyc(1, 4'h0, 4'h0, 1'b1, 32'h5555_AAAA);
        chk("rst mem_req", 64'(bus_rr.o_mem_req), 64'(1'b0));
        chk("rst mem_addr", 64'(bus_rr.o_mem_addr), 64'(0));
        chk("rst rvalid", 64'(bus_rr.o_rvalid), 64'(0));
        for (int c = 0; c < 5; c++) begin
            cyc(0, 4'h0, 4'h0, 1'b1, 32'h5555_AAAA);
            chk($sformatf("post-rst rvalid%0d", c), 64'(bus_rr.o_rvalid), 64'(0));
        end

        // Fixed priority: masters 1 and 3 request, master 1 always wins.
        for (int c = 0; c < 10; c++) begin
            cyc_fx(4'hA);
            chk($sformatf("fx gnt%0d", c), 64'(bus_fx.o_gnt), 64'(4'h2));
            if (c > 0) chk($sformatf("fx addr%0d", c), 64'(bus_fx.o_mem_addr), 64'(m_addr[1]));
        end
        cyc_fx(4'h8);
        chk("fx gnt m3", 64'(bus_fx.o_gnt), 64'(4'h8));
        cyc_fx(4'h0);
        chk("fx addr m3", 64'(bus_fx.o_mem_addr), 64'(m_addr[3]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised N-master to single-slave memory arbiter. It is the successor to the current request-only interconnect and adds separate write enable, grant handshakes, slave back-pressure, and fixed-latency read-response routing back to the issuing master. It sits between vertex fetch, shader core, framebuffer and texture masters and the DRAM port at GPU top level.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- RD_LATENCY, 2, cycles from slave accept to valid i_mem_rdata (1..8).
- MAX_GRANTS, 4, max consecutive grants to one master while others wait (1..16).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_req, in, NUM_MASTERS, per-master request; must be held with its attributes until granted.
- i_we, in, NUM_MASTERS, per-master write enable (1 = write).
- i_addr, in, NUM_MASTERS x ADDR_WIDTH, per-master address.
- i_wdata, in, NUM_MASTERS x DATA_WIDTH, per-master write data.
- o_gnt, out, NUM_MASTERS, one-hot; request captured this cycle.
- o_rvalid, out, NUM_MASTERS, one-hot read-data valid.
- o_rdata, out, DATA_WIDTH, read data; meaningful only with o_rvalid.
- o_mem_req, out, 1, slave request.
- o_mem_we, out, 1, slave write enable.
- o_mem_addr, out, ADDR_WIDTH, slave address.
- o_mem_wdata, out, DATA_WIDTH, slave write data.
- i_mem_ready, in, 1, slave accepts when o_mem_req && i_mem_ready.
- i_mem_rdata, in, DATA_WIDTH, slave read data, valid RD_LATENCY cycles after a read accept.

Behaviour:
- Reset values (async, rst_n low): all outputs 0; rotation pointer = 0; grant counter = 0; response pipeline cleared.
- Issue register: o_mem_req/we/addr/wdata come from a single output register.
  - The register can load when it is empty, or when it is full and being accepted this cycle.
  - o_gnt is combinational: asserted for the chosen master only in a cycle where the register can load.
  - No grant is issued while the register is full and i_mem_ready is 0.
- Latency: a request granted at cycle t appears on o_mem_req at t+1. With i_mem_ready held high, one transaction is issued per cycle.
- Round-robin (ARB_MODE 0):
  - Search starts at the pointer and wraps modulo NUM_MASTERS.
  - The current owner keeps priority while it still requests and its grant counter < MAX_GRANTS.
  - Otherwise the pointer becomes owner+1 (with wrap) and the counter resets to 1 on the next grant.
  - A lone requester is granted indefinitely; its counter saturates and does not block it.
- Fixed priority (ARB_MODE 1): lowest-index requester wins; the pointer and counter are ignored.
- Response routing:
  - On each accepted read, the master ID plus a valid bit enter a RD_LATENCY-deep shift pipeline. Writes enter an invalid slot.
  - When the slot emerges, i_mem_rdata is registered: o_rdata and o_rvalid[id] are asserted the following cycle (accept + RD_LATENCY + 1), for exactly one cycle.
  - The pipeline shifts every cycle regardless of i_mem_ready. Masters cannot stall responses.
- Writes produce no response. Write and read ordering at the slave equals grant order.
- Simultaneous events:
  - Accept and new grant in the same cycle: the register reloads with no bubble.
  - Response delivery and a new grant in the same cycle are independent.
- Reset mid-operation: in-flight responses are discarded and no o_rvalid follows reset release. Masters must reissue.
- Widths: ID width is $clog2(NUM_MASTERS), minimum 1. Counter width is $clog2(MAX_GRANTS+1).
- Assertions:
  - o_gnt and o_rvalid are onehot0.
  - A master's i_req must not drop before it is granted.

Decomposition:
- Shared package gpu_mem_pkg: arb_mode_e enum (ARB_RR, ARB_FIXED) and a mem_req_t struct (we, addr, wdata) parametrised by the localparams in the package.
- One natural sub-module: rr_arbiter (pointer, grant counter, one-hot grant, combinational select). The response pipeline and issue register stay in the top-level block.

Test Plan:
- Single read: master 1 reads 0x100 with i_mem_ready=1 and RD_LATENCY=2 -> o_gnt=0b0010 at t, o_mem_req with addr 0x100 and we=0 at t+1, o_rvalid=0b0010 with slave data at t+4.
- All four masters request continuously, MAX_GRANTS=2 -> grant order 0,0,1,1,2,2,3,3,0 with no idle cycles on o_mem_req.
- Back-pressure: i_mem_ready=0 for 5 cycles while masters 0 and 2 request -> o_mem_req stays high with the same addr/we/wdata, no new o_gnt, resuming one grant per cycle when ready returns.
- Mixed traffic: master 0 writes 0xDEAD to 0x40, then master 3 reads 0x40 -> write is issued first with we=1, read response goes to o_rvalid[3] only, and no o_rvalid occurs for the write.
- ARB_MODE=1 with masters 1 and 3 requesting continuously for 10 cycles -> all grants go to master 1 and master 3 is starved.
- rst_n pulsed low 1 cycle after two reads are accepted -> outputs go to 0 immediately and no o_rvalid is seen for those reads after release.
